// File: rtl/audio_level_meter.sv
// Sound level meter: windowed mean-absolute level with log2 bar index and a
// peak-hold envelope that decays exponentially, both advancing only on samples.
module audio_level_meter #(
    parameter int SAMPLE_DEPTH = 16,
    parameter int WINDOW_LOG2  = 8,
    parameter int HOLD_SAMPLES = 1000,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic signed [SAMPLE_DEPTH-1:0]  audio_in,
    input  logic                            audio_valid,
    output logic [SAMPLE_DEPTH-2:0]         level,
    output logic                            level_valid,
    output logic [SAMPLE_DEPTH-2:0]         peak,
    output logic [$clog2(SAMPLE_DEPTH)-1:0] bar
);
    localparam int MAG_W  = SAMPLE_DEPTH - 1;
    localparam int ACC_W  = MAG_W + WINDOW_LOG2;
    localparam int CNT_W  = (WINDOW_LOG2 > 0) ? WINDOW_LOG2 : 1;
    localparam int HOLD_W = $clog2(HOLD_SAMPLES + 1);
    localparam int BAR_W  = $clog2(SAMPLE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << WINDOW_LOG2) - 1);

    logic [SAMPLE_DEPTH-1:0] in_bits;
    logic [SAMPLE_DEPTH-1:0] abs_full;
    logic [MAG_W-1:0]        abs_sat;
    logic [MAG_W-1:0]        abs_s_reg;
    logic                    abs_v_reg;

    logic [ACC_W-1:0]        acc_reg;
    logic [ACC_W-1:0]        win_sum;
    logic [CNT_W-1:0]        cnt_reg;
    logic [MAG_W-1:0]        level_next;
    logic [MAG_W-1:0]        level_reg;
    logic                    level_valid_reg;
    logic [BAR_W-1:0]        bar_reg;

    logic [MAG_W-1:0]        peak_reg;
    logic [HOLD_W-1:0]       hold_reg;
    logic [MAG_W-1:0]        decay_step;

    // Index of the highest set bit plus one; zero for a zero input.
    function automatic logic [BAR_W-1:0] bar_of(input logic [MAG_W-1:0] v);
        bar_of = '0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) bar_of = BAR_W'(i + 1);
        end
    endfunction

    // Negating the most negative sample overflows into the sign bit; clamp it.
    assign in_bits  = audio_in;
    assign abs_full = in_bits[SAMPLE_DEPTH-1] ? (~in_bits + SAMPLE_DEPTH'(1)) : in_bits;
    assign abs_sat  = abs_full[SAMPLE_DEPTH-1] ? '1 : abs_full[MAG_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            abs_s_reg <= '0;
            abs_v_reg <= 1'b0;
        end else begin
            abs_v_reg <= audio_valid;
            if (audio_valid) abs_s_reg <= abs_sat;
        end
    end

    assign win_sum    = acc_reg + ACC_W'(abs_s_reg);
    assign level_next = win_sum[ACC_W-1:WINDOW_LOG2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg         <= '0;
            cnt_reg         <= '0;
            level_reg       <= '0;
            level_valid_reg <= 1'b0;
            bar_reg         <= '0;
        end else begin
            level_valid_reg <= 1'b0;
            if (abs_v_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg       <= level_next;
                    bar_reg         <= bar_of(level_next);
                    level_valid_reg <= 1'b1;
                    acc_reg         <= '0;
                    cnt_reg         <= '0;
                end else begin
                    acc_reg <= win_sum;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Small peaks still decay by at least one so the envelope reaches zero.
    always_comb begin
        decay_step = peak_reg >> DECAY_SHIFT;
        if (decay_step == '0) decay_step = MAG_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            peak_reg <= '0;
            hold_reg <= '0;
        end else if (abs_v_reg) begin
            if (abs_s_reg >= peak_reg) begin
                peak_reg <= abs_s_reg;
                hold_reg <= HOLD_W'(HOLD_SAMPLES);
            end else if (hold_reg != '0) begin
                hold_reg <= hold_reg - HOLD_W'(1);
            end else if (peak_reg != '0) begin
                peak_reg <= peak_reg - decay_step;
            end
        end
    end

    assign level       = level_reg;
    assign level_valid = level_valid_reg;
    assign peak        = peak_reg;
    assign bar         = bar_reg;
endmodule

// File: tb/tb_audio_level_meter.sv
// Directed bench: one meter with a 4-sample window and short hold, and one with a
// single-sample window so level/bar track each sample directly.
module tb_audio_level_meter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic signed [15:0] audio_in;
    logic               audio_valid;
    logic [14:0]        level_a, peak_a, level_b, peak_b;
    logic               lv_a, lv_b;
    logic [3:0]         bar_a, bar_b;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        int sample;
        int exp_peak_a;
        int exp_level_b;
        int exp_bar_b;
    } vec_t;
    vec_t vecs[14];

    audio_level_meter #(.SAMPLE_DEPTH(16), .WINDOW_LOG2(2), .HOLD_SAMPLES(3), .DECAY_SHIFT(4)) dut_a (
        .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid),
        .level(level_a), .level_valid(lv_a), .peak(peak_a), .bar(bar_a)
    );

    audio_level_meter #(.SAMPLE_DEPTH(16), .WINDOW_LOG2(0), .HOLD_SAMPLES(1000), .DECAY_SHIFT(4)) dut_b (
        .clk(clk), .rst(rst), .audio_in(audio_in), .audio_valid(audio_valid),
        .level(level_b), .level_valid(lv_b), .peak(peak_b), .bar(bar_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Strobe one sample; returns on the falling edge after it was captured.
    task automatic send(input int x);
        @(negedge clk);
        audio_in    = 16'(x);
        audio_valid = 1'b1;
        @(negedge clk);
        audio_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int  prev;
        bit  reached;
        bit  saw_small;

        rst         = 1'b0;
        audio_in    = '0;
        audio_valid = 1'b0;

        vecs[0]  = '{20000,  20000, 20000, 15};
        vecs[1]  = '{0,      20000, 0,     0};
        vecs[2]  = '{0,      20000, 0,     0};
        vecs[3]  = '{0,      20000, 0,     0};
        vecs[4]  = '{0,      18750, 0,     0};
        vecs[5]  = '{0,      17579, 0,     0};
        vecs[6]  = '{17579,  17579, 17579, 15};
        vecs[7]  = '{5,      17579, 5,     3};
        vecs[8]  = '{1,      17579, 1,     1};
        vecs[9]  = '{-1,     17579, 1,     1};
        vecs[10] = '{0,      16481, 0,     0};
        vecs[11] = '{-32768, 32767, 32767, 15};
        vecs[12] = '{32767,  32767, 32767, 15};
        vecs[13] = '{256,    32767, 256,   9};

        do_reset();
        @(negedge clk);
        check("reset level_a", int'(level_a), 0);
        check("reset lv_a", int'(lv_a), 0);
        check("reset peak_a", int'(peak_a), 0);
        check("reset bar_a", int'(bar_a), 0);
        check("reset level_b", int'(level_b), 0);
        check("reset peak_b", int'(peak_b), 0);

        // Four spaced samples of +1000.
        for (int i = 0; i < 4; i++) begin
            send(1000);
            if (i < 3) begin
                check("t1 no early lv", int'(lv_a), 0);
                repeat (6) @(negedge clk);
            end
        end
        check("t1 lv one clk after", int'(lv_a), 0);
        @(negedge clk);
        check("t1 lv two clk after", int'(lv_a), 1);
        check("t1 level", int'(level_a), 1000);
        check("t1 bar", int'(bar_a), 10);
        @(negedge clk);
        check("t1 lv drops", int'(lv_a), 0);
        $display("[TB] t1 level=%0d bar=%0d peak=%0d", level_a, bar_a, peak_a);

        // Back-to-back samples; the last one also starts peak decay.
        @(negedge clk); audio_in = 16'sd100;  audio_valid = 1'b1;
        @(negedge clk); audio_in = -16'sd100;
        @(negedge clk); audio_in = 16'sd300;
        @(negedge clk); audio_in = -16'sd300;
        @(negedge clk); audio_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("t2 lv cycle %0d", k), int'(lv_a), (k == 1) ? 1 : 0);
            if (k == 1) begin
                check("t2 level", int'(level_a), 200);
                check("t2 bar", int'(bar_a), 8);
                check("t2 peak decay", int'(peak_a), 938);
            end
        end
        $display("[TB] t2 level=%0d bar=%0d peak=%0d", level_a, bar_a, peak_a);

        // Partial window discarded by a mid-window reset.
        send(1000);
        send(1000);
        do_reset();
        check("t5 reset peak", int'(peak_a), 0);
        check("t5 reset level", int'(level_a), 0);
        check("t5 reset bar", int'(bar_a), 0);
        for (int i = 0; i < 4; i++) begin
            send(50);
            @(negedge clk);
            check($sformatf("t5 lv after sample %0d", i), int'(lv_a), (i == 3) ? 1 : 0);
        end
        check("t5 level", int'(level_a), 50);
        check("t5 peak", int'(peak_a), 50);
        check("t5 level_b", int'(level_b), 50);
        check("t5 bar_b", int'(bar_b), 6);
        repeat (10) @(negedge clk);
        check("idle level held", int'(level_a), 50);
        check("idle peak held", int'(peak_a), 50);
        check("idle bar held", int'(bar_a), 6);
        check("idle lv low", int'(lv_a), 0);
        $display("[TB] t5 level=%0d peak=%0d", level_a, peak_a);

        // Peak hold/decay/retrigger table, with per-sample level on dut_b.
        do_reset();
        foreach (vecs[i]) begin
            send(vecs[i].sample);
            @(negedge clk);
            check($sformatf("vec%0d peak_a", i), int'(peak_a), vecs[i].exp_peak_a);
            check($sformatf("vec%0d level_b", i), int'(level_b), vecs[i].exp_level_b);
            check($sformatf("vec%0d bar_b", i), int'(bar_b), vecs[i].exp_bar_b);
            check($sformatf("vec%0d lv_b", i), int'(lv_b), 1);
            $display("[TB] vec%0d in=%0d peak_a=%0d level_b=%0d bar_b=%0d",
                     i, vecs[i].sample, peak_a, level_b, bar_b);
        end

        // Zeros until the envelope reaches zero, with a bounded sample budget.
        reached   = 1'b0;
        saw_small = 1'b0;
        for (int n = 0; n < 400; n++) begin
            prev = int'(peak_a);
            send(0);
            @(negedge clk);
            if (!saw_small && prev > 0 && prev < 16) begin
                saw_small = 1'b1;
                check("t4 min decrement", int'(peak_a), prev - 1);
            end
            if (peak_a == 15'd0) begin
                reached = 1'b1;
                break;
            end
        end
        check("t4 reached zero", int'(reached), 1);
        check("t4 small path seen", int'(saw_small), 1);
        send(0);
        send(0);
        @(negedge clk);
        check("t4 stays zero", int'(peak_a), 0);
        $display("[TB] t4 final peak=%0d", peak_a);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
